// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner state type, reset column pattern and key-code map
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Nibble {row,col} of this table is the key code printed on that button
    localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return KEY_TABLE[{row_idx, col_idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sync.sv
// sync: two-flop synchronizer for asynchronous input lines
module sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two register stages, no reset, so a metastable first stage settles before use
    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad scanner with press/release debounce; GHOST_REJECT_EN rejects multi-row presses
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES = 4,
    parameter int DB_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int CW = $clog2(SCAN_CYCLES > DB_CYCLES ? SCAN_CYCLES : DB_CYCLES);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);

    scan_state_t   state, state_n;
    logic [1:0]    col, col_n, row, row_n, first_low;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    rows_s, low, key_n;
    logic          key_valid_n, row_low, press, abort;

    sync #(.W(4)) u_sync (.clk(clk), .d(rows), .q(rows_s));

    assign low       = ~rows_s;
    assign row_low   = low[row];
    assign first_low = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    assign cols      = ~(~COL_RESET << col);

`ifdef GHOST_REJECT_EN
    assign press = |low && !(|(low & (low - 4'd1)));
    assign abort = |(low & ~(4'b0001 << row));
`else
    assign press = |low;
    assign abort = 1'b0;
`endif

    // Next-state logic: scan dwell, press debounce, hold, release debounce
    always_comb begin
        state_n     = state;
        col_n       = col;
        row_n       = row;
        cnt_n       = cnt;
        key_n       = key;
        key_valid_n = 1'b0;
        case (state)
            SCAN: begin
                cnt_n = (cnt == SCAN_LAST) ? '0 : cnt + 1'b1;
                if (cnt == SCAN_LAST && press) begin
                    state_n = DEBOUNCE;
                    row_n   = first_low;
                end else if (cnt == SCAN_LAST) begin
                    col_n = col + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_low || abort) begin
                    state_n = SCAN;
                    col_n   = col + 1'b1;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n     = HELD;
                    key_n       = keymap(row, col);
                    key_valid_n = 1'b1;
                    cnt_n       = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!row_low) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                end
            end
            RELEASE: begin
                if (row_low) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = SCAN;
                    col_n   = col + 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    // State register; reset drops any pending strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col       <= 2'd0;
            row       <= 2'd0;
            cnt       <= '0;
            key       <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            cnt       <= cnt_n;
            key       <= key_n;
            key_valid <= key_valid_n;
        end
    end

endmodule
